// File: rtl/lif_pkg.sv
// Shared types and arithmetic helpers for the LIF neuron array.
package lif_pkg;

    typedef enum logic {
        IDLE,
        COMMIT
    } cfg_state_t;

    // Unsigned add clamped to the largest value representable in 'width' bits.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input int unsigned width);
        logic [32:0] sum;
        logic [32:0] max_val;
        sum     = {1'b0, a} + {1'b0, b};
        max_val = (33'd1 << width) - 33'd1;
        return (sum > max_val) ? max_val[31:0] : sum[31:0];
    endfunction

    function automatic logic [4:0] popcount(input logic [15:0] bits);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < 16; i++) begin
            n = n + 5'(bits[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/lif_neuron_array_if.sv
// Threshold configuration handshake between a host and the neuron array.
interface lif_neuron_array_if #(
    parameter int W = 6
);
    logic         cfg_valid;
    logic         cfg_ready;
    logic [3:0]   cfg_ch;
    logic [W-1:0] cfg_th;
    logic         cfg_err;

    modport master (
        output cfg_valid,
        output cfg_ch,
        output cfg_th,
        input  cfg_ready,
        input  cfg_err
    );

    modport slave (
        input  cfg_valid,
        input  cfg_ch,
        input  cfg_th,
        output cfg_ready,
        output cfg_err
    );
endinterface

// File: rtl/lif_channel.sv
// One leaky integrate-and-fire neuron: potential, threshold and refractory counter.
module lif_channel
    import lif_pkg::*;
#(
    parameter int W          = 6,
    parameter int LEAK_SHIFT = 1,
    parameter int REFRAC     = 2,
    parameter int TH_INIT    = 2 ** (W - 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         step_en,
    input  logic [W-1:0] in_cur,
    input  logic         reset_mode,
    input  logic         th_we,
    input  logic [W-1:0] th_wdata,
    output logic         fire,
    output logic         spike,
    output logic [W-1:0] v
);

    localparam int RC_W = (REFRAC > 1) ? $clog2(REFRAC + 1) : 1;

    logic [W-1:0]    v_reg, v_next;
    logic [W-1:0]    th_reg;
    logic [RC_W-1:0] rc_reg, rc_next;
    logic            spike_reg;
    logic [W-1:0]    leaked;
    logic [W-1:0]    sum;

    always_comb begin
        v_next  = v_reg;
        rc_next = rc_reg;
        fire    = 1'b0;
        leaked  = v_reg - (v_reg >> LEAK_SHIFT);
        sum     = W'(sat_add(32'(leaked), 32'(in_cur), W));
        // A zero threshold disables the channel without touching its refractory state.
        if (th_reg == '0) begin
            v_next = '0;
        end else if (rc_reg != '0) begin
            rc_next = rc_reg - RC_W'(1);
            v_next  = '0;
        end else if (sum >= th_reg) begin
            fire    = 1'b1;
            rc_next = RC_W'(REFRAC);
            v_next  = reset_mode ? (sum - th_reg) : '0;
        end else begin
            v_next = sum;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v_reg     <= '0;
            th_reg    <= W'(TH_INIT);
            rc_reg    <= '0;
            spike_reg <= 1'b0;
        end else begin
            if (step_en) begin
                v_reg     <= v_next;
                rc_reg    <= rc_next;
                spike_reg <= fire;
            end else begin
                spike_reg <= 1'b0;
            end
            // The step above already compared against the old value.
            if (th_we) begin
                th_reg <= th_wdata;
            end
        end
    end

    assign spike = spike_reg;
    assign v     = v_reg;

endmodule

// File: rtl/lif_neuron_array.sv
// Array of LIF neurons with a threshold configuration port and a saturating spike counter.
module lif_neuron_array
    import lif_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int W          = 6,
    parameter int LEAK_SHIFT = 1,
    parameter int REFRAC     = 2,
    parameter int TH_INIT    = 2 ** (W - 1),
    parameter int CNT_W      = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                step_en,
    input  logic [N_CH*W-1:0]   in_cur,
    input  logic                reset_mode,
    lif_neuron_array_if.slave   cfg,
    output logic [N_CH-1:0]     spike,
    output logic [N_CH*W-1:0]   potential,
    output logic [CNT_W-1:0]    spike_cnt,
    input  logic                clr_cnt
);

    cfg_state_t       state_reg, state_next;
    logic             accept;
    logic             cfg_ready_c;
    logic             ch_valid;
    logic             cfg_err_reg;
    logic [N_CH-1:0]  fire;
    logic [N_CH-1:0]  th_we;
    logic [4:0]       step_pop;
    logic [CNT_W-1:0] cnt_reg;

    assign ch_valid = ({1'b0, cfg.cfg_ch} < 5'(N_CH));

    always_comb begin
        state_next  = state_reg;
        cfg_ready_c = 1'b0;
        accept      = 1'b0;
        case (state_reg)
            IDLE: begin
                cfg_ready_c = 1'b1;
                if (cfg.cfg_valid) begin
                    accept     = 1'b1;
                    state_next = COMMIT;
                end
            end
            COMMIT: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            cfg_err_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cfg_err_reg <= accept && !ch_valid;
        end
    end

    assign cfg.cfg_ready = cfg_ready_c;
    assign cfg.cfg_err   = cfg_err_reg;

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            assign th_we[gi] = accept && ch_valid && (cfg.cfg_ch == 4'(gi));

            lif_channel #(
                .W          (W),
                .LEAK_SHIFT (LEAK_SHIFT),
                .REFRAC     (REFRAC),
                .TH_INIT    (TH_INIT)
            ) u_channel (
                .clk        (clk),
                .reset      (reset),
                .step_en    (step_en),
                .in_cur     (in_cur[gi*W +: W]),
                .reset_mode (reset_mode),
                .th_we      (th_we[gi]),
                .th_wdata   (cfg.cfg_th),
                .fire       (fire[gi]),
                .spike      (spike[gi]),
                .v          (potential[gi*W +: W])
            );
        end
    endgenerate

    assign step_pop = popcount(16'(fire));

    // Clear wins over a same-cycle increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg <= '0;
        end else if (clr_cnt) begin
            cnt_reg <= '0;
        end else if (step_en) begin
            cnt_reg <= CNT_W'(sat_add(32'(cnt_reg), 32'(step_pop), CNT_W));
        end
    end

    assign spike_cnt = cnt_reg;

endmodule

// File: tb/tb_lif_neuron_array.sv
// Self-checking bench for lif_neuron_array: directed tables, corner sequences, random vs. model.
module tb_lif_neuron_array;

    localparam int N   = 4;
    localparam int W   = 6;
    localparam int LS  = 1;
    localparam int RF  = 2;
    localparam int VMX = 63;
    localparam int CMX = 255;

    logic            clk = 1'b0;
    logic            reset;
    logic            step_en;
    logic [N*W-1:0]  in_cur;
    logic            reset_mode;
    logic [N-1:0]    spike;
    logic [N*W-1:0]  potential;
    logic [7:0]      spike_cnt;
    logic            clr_cnt;

    int checks   = 0;
    int failures = 0;

    lif_neuron_array_if #(.W(W)) cfg_if ();

    lif_neuron_array dut (
        .clk        (clk),
        .reset      (reset),
        .step_en    (step_en),
        .in_cur     (in_cur),
        .reset_mode (reset_mode),
        .cfg        (cfg_if),
        .spike      (spike),
        .potential  (potential),
        .spike_cnt  (spike_cnt),
        .clr_cnt    (clr_cnt)
    );

    always #5 clk = ~clk;

    // Reference model state
    int m_v[N];
    int m_th[N];
    int m_rc[N];
    bit m_spk[N];
    int m_cnt;
    bit m_busy;
    bit m_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_v[k] = 0; m_th[k] = 32; m_rc[k] = 0; m_spk[k] = 0;
        end
        m_cnt = 0; m_busy = 0; m_err = 0;
    endtask

    // Advances the model by one clock edge using the currently driven inputs.
    task automatic model_edge();
        int  fired;
        int  sum;
        int  in_k;
        int  ch;
        bit  acc;
        fired = 0;
        acc   = cfg_if.cfg_valid && !m_busy;
        for (int k = 0; k < N; k++) begin
            if (!step_en) begin
                m_spk[k] = 0;
            end else if (m_th[k] == 0) begin
                m_v[k] = 0; m_spk[k] = 0;
            end else if (m_rc[k] > 0) begin
                m_rc[k]--; m_v[k] = 0; m_spk[k] = 0;
            end else begin
                in_k = int'(in_cur[k*W +: W]);
                sum  = m_v[k] - (m_v[k] / (2 ** LS)) + in_k;
                if (sum > VMX) sum = VMX;
                if (sum >= m_th[k]) begin
                    m_spk[k] = 1; fired++; m_rc[k] = RF;
                    m_v[k] = reset_mode ? sum - m_th[k] : 0;
                end else begin
                    m_v[k] = sum; m_spk[k] = 0;
                end
            end
        end
        if (clr_cnt) m_cnt = 0;
        else if (step_en) m_cnt = (m_cnt + fired > CMX) ? CMX : m_cnt + fired;
        ch = int'(cfg_if.cfg_ch);
        if (acc && ch < N) m_th[ch] = int'(cfg_if.cfg_th);
        m_err  = acc && (ch >= N);
        m_busy = acc;
    endtask

    task automatic compare_all(input string tag);
        logic [N*W-1:0] ep;
        logic [N-1:0]   es;
        for (int k = 0; k < N; k++) begin
            ep[k*W +: W] = W'(m_v[k]);
            es[k]        = m_spk[k];
        end
        chk({tag, ".potential"}, 32'(potential), 32'(ep));
        chk({tag, ".spike"}, 32'(spike), 32'(es));
        chk({tag, ".spike_cnt"}, 32'(spike_cnt), 32'(m_cnt));
        chk({tag, ".cfg_ready"}, 32'(cfg_if.cfg_ready), 32'(!m_busy));
        chk({tag, ".cfg_err"}, 32'(cfg_if.cfg_err), 32'(m_err));
        $display("txn %s step=%0b in=%h pot=%h spk=%b cnt=%0d rdy=%0b err=%0b",
                 tag, step_en, in_cur, potential, spike, spike_cnt,
                 cfg_if.cfg_ready, cfg_if.cfg_err);
    endtask

    task automatic tick(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    task automatic idle_inputs();
        step_en = 0; in_cur = '0; reset_mode = 0; clr_cnt = 0;
        cfg_if.cfg_valid = 0; cfg_if.cfg_ch = '0; cfg_if.cfg_th = '0;
    endtask

    // Pulses reset between clock edges and checks the immediate effect.
    task automatic do_reset(input string tag);
        idle_inputs();
        #2 reset = 1;
        #2;
        model_reset();
        compare_all(tag);
        #1 reset = 0;
    endtask

    typedef struct {
        bit             step;
        bit             mode;
        logic [N*W-1:0] inp;
        logic [N*W-1:0] exp_pot;
        logic [N-1:0]   exp_spk;
        int             exp_cnt;
    } vec_t;

    vec_t tbl[6];

    initial begin
        // Integrate and refractory on ch0 with in=20, th=32, reset-to-zero.
        tbl[0] = '{1, 0, 24'd20, 24'd20, 4'b0000, 0};
        tbl[1] = '{1, 0, 24'd20, 24'd30, 4'b0000, 0};
        tbl[2] = '{1, 0, 24'd20, 24'd0,  4'b0001, 1};
        tbl[3] = '{1, 0, 24'd20, 24'd0,  4'b0000, 1};
        tbl[4] = '{1, 0, 24'd20, 24'd0,  4'b0000, 1};
        tbl[5] = '{1, 0, 24'd20, 24'd20, 4'b0000, 1};

        idle_inputs();
        reset = 1;
        model_reset();
        #3;
        compare_all("init_reset");
        #4 reset = 0;

        step_en = 1;
        tick("zero_step");

        for (int i = 0; i < 6; i++) begin
            step_en = tbl[i].step; reset_mode = tbl[i].mode; in_cur = tbl[i].inp;
            tick($sformatf("integ%0d", i));
            chk($sformatf("integ%0d.pot_tbl", i), 32'(potential), 32'(tbl[i].exp_pot));
            chk($sformatf("integ%0d.spk_tbl", i), 32'(spike), 32'(tbl[i].exp_spk));
            chk($sformatf("integ%0d.cnt_tbl", i), 32'(spike_cnt), 32'(tbl[i].exp_cnt));
        end

        // Subtract mode with saturation on ch1, th=40.
        do_reset("rst_sub");
        cfg_if.cfg_valid = 1; cfg_if.cfg_ch = 4'd1; cfg_if.cfg_th = 6'd40;
        tick("sub_cfg");
        cfg_if.cfg_valid = 0;
        tick("sub_commit");
        step_en = 1; reset_mode = 1; in_cur = 24'(63 << W);
        tick("sub1"); chk("sub1.v1", 32'(potential[11:6]), 32'd23); chk("sub1.s1", 32'(spike[1]), 1);
        tick("sub2"); chk("sub2.v1", 32'(potential[11:6]), 32'd0);  chk("sub2.s1", 32'(spike[1]), 0);
        tick("sub3"); chk("sub3.v1", 32'(potential[11:6]), 32'd0);
        tick("sub4"); chk("sub4.v1", 32'(potential[11:6]), 32'd23); chk("sub4.cnt", 32'(spike_cnt), 2);

        // Config handshake: good write, out-of-range write, held valid.
        do_reset("rst_cfg");
        cfg_if.cfg_valid = 1; cfg_if.cfg_ch = 4'd2; cfg_if.cfg_th = 6'd10;
        tick("cfg_ch2");
        chk("cfg_ch2.ready", 32'(cfg_if.cfg_ready), 0);
        chk("cfg_ch2.err", 32'(cfg_if.cfg_err), 0);
        cfg_if.cfg_valid = 0;
        tick("cfg_ch2_commit");
        cfg_if.cfg_valid = 1; cfg_if.cfg_ch = 4'd5; cfg_if.cfg_th = 6'd1;
        tick("cfg_ch5");
        chk("cfg_ch5.err", 32'(cfg_if.cfg_err), 1);
        cfg_if.cfg_valid = 0;
        tick("cfg_ch5_after");
        chk("cfg_ch5.err_pulse", 32'(cfg_if.cfg_err), 0);
        cfg_if.cfg_valid = 1; cfg_if.cfg_ch = 4'd3; cfg_if.cfg_th = 6'd5;
        tick("cfg_hold_a");
        cfg_if.cfg_th = 6'd50;
        tick("cfg_hold_b");
        cfg_if.cfg_valid = 0;
        step_en = 1; in_cur = {6'd5, 6'd10, 6'd0, 6'd0};
        tick("cfg_probe");
        chk("cfg_probe.spk", 32'(spike), 32'b1100);

        // Threshold write colliding with a step uses the old threshold.
        do_reset("rst_coll");
        step_en = 1; in_cur = 24'd20;
        tick("coll_a");
        tick("coll_b");
        cfg_if.cfg_valid = 1; cfg_if.cfg_ch = 4'd0; cfg_if.cfg_th = 6'd63;
        tick("coll_c");
        chk("coll_c.spk0", 32'(spike[0]), 1);
        cfg_if.cfg_valid = 0; in_cur = '0;
        tick("coll_rc1");
        tick("coll_rc2");
        in_cur = 24'd20;
        tick("coll_d");
        tick("coll_e");
        tick("coll_f");
        chk("coll_f.spk0", 32'(spike[0]), 0);
        chk("coll_f.v0", 32'(potential[5:0]), 32'd35);

        // Asynchronous reset while ch0 is refractory.
        do_reset("rst_ar");
        step_en = 1; in_cur = 24'd20;
        tick("ar_a");
        tick("ar_b");
        tick("ar_c");
        chk("ar_c.spk0", 32'(spike[0]), 1);
        do_reset("ar_reset");
        chk("ar_reset.cnt", 32'(spike_cnt), 0);
        step_en = 1; in_cur = 24'd20;
        tick("ar_after");
        chk("ar_after.v0", 32'(potential[5:0]), 32'd20);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            step_en          = ($urandom_range(0, 3) != 0);
            in_cur           = 24'($urandom);
            reset_mode       = 1'($urandom);
            clr_cnt          = ($urandom_range(0, 149) == 0);
            cfg_if.cfg_valid = ($urandom_range(0, 3) == 0);
            cfg_if.cfg_ch    = 4'($urandom_range(0, 7));
            cfg_if.cfg_th    = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
            tick($sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
